sram_weight_stream: RTL and testbench
=====================================

// Module: sram_weight_stream
// PURPOSE
//  Parametrised weight SRAM for the systolic array. It replaces the fixed 16x128b store.
//  Storage is DEPTH words of LANES x LANE_W bits, with per-lane write masking.
//  Read latency is configurable and read-during-write behaviour is selectable.
//  A burst-read sequencer streams LEN consecutive words (address wrap-around) with a valid
//  strobe, so the array controller feeds weights without issuing one address per cycle.
// PARAMETERS
//  LANE_W   16   bits per weight lane
//  LANES    8    lanes per word; word width W = LANES*LANE_W
//  DEPTH    16   words; ADDR_W = $clog2(DEPTH), minimum 1
//  RD_LAT   1    cycles from accepted read to rdata/rvalid, legal range 1..3
//  BYPASS   0    1: same-address read during write returns new (masked-merged) data; 0: old data
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous reset, active-high
//  csb          in   1        chip select, active-low; gates direct reads and all writes
//  wsb          in   1        write enable, active-low; write when ~csb & ~wsb
//  wmask        in   LANES    per-lane write enable, 1 = lane written
//  wdata        in   W        write data, lane i = wdata[i*LANE_W +: LANE_W]
//  waddr        in   ADDR_W   write address
//  raddr        in   ADDR_W   direct read address
//  burst_start  in   1        1-cycle pulse, starts a burst when idle
//  burst_base   in   ADDR_W   first burst address, sampled with burst_start
//  burst_len    in   ADDR_W+1 words in burst, 0..DEPTH, sampled with burst_start
//  rdata        out  W        read data, held until the next valid read
//  rvalid       out  1        1-cycle strobe per delivered word
//  burst_busy   out  1        high while the sequencer owns the read port
//  burst_done   out  1        1-cycle pulse when the last burst word is delivered on rdata
// BEHAVIOUR
//  - Reset: rdata=0, rvalid=0, burst_busy=0, burst_done=0, FSM=IDLE, pipeline valid bits cleared.
//    The memory array is not reset.
//  - Write: at posedge with ~csb & ~wsb, mem[waddr] lanes with wmask=1 are updated; other lanes are kept.
//    Writes are allowed in every FSM state, including during a burst.
//  - Direct read: accepted when ~csb & ~burst_busy. The word at raddr appears on rdata with rvalid=1
//    exactly RD_LAT cycles after the accepting edge. This is one read per cycle, fully pipelined.
//  - Collision (read addr == waddr on the same edge as a write):
//    - BYPASS=1: returns the old word with the masked lanes replaced by wdata.
//    - BYPASS=0: returns the old word.
//    - Applies to both direct and burst reads.
//  - FSM states:
//    - IDLE: burst_start & burst_len!=0 -> BURST; load addr=burst_base, cnt=burst_len.
//      burst_start & burst_len==0 -> no reads, burst_done pulses the next cycle, stay IDLE.
//    - BURST: issue one read per cycle at addr; addr wraps DEPTH-1 -> 0; cnt decrements.
//      On the edge that issues the last read -> DRAIN.
//    - DRAIN: wait until the last word leaves the pipeline. burst_done=1 with that word's rvalid -> IDLE.
//    - burst_busy=1 in BURST and DRAIN. It goes high the cycle after burst_start and low the cycle after burst_done.
//  - burst_start while burst_busy is ignored. A direct read while burst_busy is ignored and produces no rvalid.
//  - A direct read accepted on the same edge as burst_start wins that edge. The burst issues its first read on the next edge.
//  - csb does not stall a burst in progress.
//  - Reset mid-burst or mid-pipeline: all in-flight reads are dropped, no rvalid and no burst_done are produced, and the FSM returns to IDLE.
//  - Out-of-range addresses (DEPTH not a power of 2): writes are dropped and reads return 0.
// STRUCTURE
//  - Shared package sram_pkg:
//    - FSM state enum {IDLE, BURST, DRAIN}
//    - function addr_w(depth) = max(1, $clog2(depth))
//    - localparam RD_LAT_MAX = 3
//  - Sub-module sram_rd_pipe: RD_LAT-stage shift register carrying {valid, last, data}.
//    It is cleared by rst and drives rvalid, burst_done and rdata (rdata loads only on a valid word).
//  - The top level holds the memory array, the write-mask merge, the collision mux and the sequencer FSM.
// TESTING
//  1. Write/readback: DEPTH=16, RD_LAT=2. Write word k = {8{k[15:0]}} to all 16 addresses, then direct-read 0..15 back-to-back
//     -> 16 consecutive rvalid pulses starting 2 cycles after the first read, data matches.
//  2. Mask: mem[3]=all 1s. Write wdata=0 with wmask=8'b0000_0101, then read 3 -> lanes 0 and 2 = 0, all other lanes = 16'hFFFF.
//  3. Collision: same edge writes addr 5 = A and reads addr 5, old value B.
//     -> BYPASS=1 returns A, BYPASS=0 returns B; a read of 5 on the next cycle returns A in both cases.
//  4. Burst wrap: base=14, len=4, RD_LAT=1 -> addresses 14,15,0,1 returned on 4 consecutive rvalid pulses.
//     burst_done coincides with the 4th pulse. A direct read issued during the burst produces no rvalid.
//  5. len=0 burst -> burst_done pulses one cycle later with no rvalid. burst_start while busy -> ignored, rvalid count unchanged.
//  6. Reset at the 2nd cycle of a len=8 burst -> rvalid, burst_busy and burst_done all 0 the next cycle.
//     A new burst base=0, len=2 then completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the weight SRAM: sequencer states, address sizing
// and the supported read-latency ceiling.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } burst_state_e;

   localparam int unsigned RD_LAT_MAX = 3;

   // A single-word memory still needs one address bit.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: RD_LAT stages of {valid, last, data}. The final stage drives
// the read strobe, the burst-done pulse and the held read data.
module sram_rd_pipe #(
   parameter int unsigned W      = 128,
   parameter int unsigned RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic         last_i,
   input  logic         empty_done_i,
   input  logic [W-1:0] data_i,
   output logic         rvalid_o,
   output logic         done_o,
   output logic [W-1:0] rdata_o
);

   logic [RD_LAT-1:0] v_q, l_q;
   logic [RD_LAT-1:0] v_chain, l_chain;
   logic [W-1:0]      d_q     [RD_LAT];
   logic [W-1:0]      d_chain [RD_LAT];

   assign v_chain = (v_q << 1) | RD_LAT'(valid_i);
   assign l_chain = (l_q << 1) | RD_LAT'(valid_i & last_i);

   always_comb begin
      d_chain[0] = data_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         d_chain[i] = d_q[i-1];
      end
   end

   // An empty burst has no data word, so its done pulse enters at the output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         l_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q <= v_chain;
         l_q <= l_chain | (RD_LAT'(empty_done_i) << (RD_LAT - 1));
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            if (v_chain[i]) begin
               d_q[i] <= d_chain[i];
            end
         end
      end
   end

   assign rvalid_o = v_q[RD_LAT-1];
   assign done_o   = l_q[RD_LAT-1];
   assign rdata_o  = d_q[RD_LAT-1];

endmodule

// File: rtl/sram_weight_stream.sv
// Weight SRAM with lane-masked writes, selectable read-during-write bypass and a
// burst sequencer that streams consecutive words to the systolic array.
module sram_weight_stream
   import sram_pkg::*;
#(
   parameter  int unsigned LANE_W = 16,
   parameter  int unsigned LANES  = 8,
   parameter  int unsigned DEPTH  = 16,
   parameter  int unsigned RD_LAT = 1,
   parameter  bit          BYPASS = 1'b0,
   localparam int unsigned W      = LANES * LANE_W,
   localparam int unsigned ADDR_W = addr_w(DEPTH),
   localparam int unsigned CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csb,
   input  logic              wsb,
   input  logic [LANES-1:0]  wmask,
   input  logic [W-1:0]      wdata,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              burst_start,
   input  logic [ADDR_W-1:0] burst_base,
   input  logic [CNT_W-1:0]  burst_len,
   output logic [W-1:0]      rdata,
   output logic              rvalid,
   output logic              burst_busy,
   output logic              burst_done
);

   localparam int unsigned LAT = (RD_LAT < 1) ? 1 :
                                 (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

   logic [W-1:0]      mem_q [DEPTH];
   burst_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q;
   logic              burst_rd_c, burst_last_c, empty_done_c, pipe_done;
   logic              wr_en, rd_en, wr_in_range, rd_in_range;
   logic [ADDR_W-1:0] rd_addr;
   logic [W-1:0]      wr_old, wr_merged, rd_old, rd_word;

   assign wr_en       = ~csb & ~wsb;
   assign wr_in_range = 32'(waddr) < DEPTH;
   assign wr_old      = wr_in_range ? mem_q[waddr] : '0;

   always_comb begin
      wr_merged = wr_old;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (wmask[l]) begin
            wr_merged[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem_q[waddr] <= wr_merged;
      end
   end

   // The sequencer owns the read port while busy; direct reads are dropped then.
   assign rd_en       = (~csb & ~busy_q) | burst_rd_c;
   assign rd_addr     = burst_rd_c ? addr_q : raddr;
   assign rd_in_range = 32'(rd_addr) < DEPTH;
   assign rd_old      = rd_in_range ? mem_q[rd_addr] : '0;
   assign rd_word     = (BYPASS && wr_en && wr_in_range && (waddr == rd_addr)) ?
                        wr_merged : rd_old;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      burst_rd_c   = 1'b0;
      burst_last_c = 1'b0;
      empty_done_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (burst_start) begin
               if (burst_len != '0) begin
                  state_d = BURST;
                  addr_d  = burst_base;
                  cnt_d   = burst_len;
               end else begin
                  empty_done_c = 1'b1;
               end
            end
         end
         BURST: begin
            burst_rd_c = 1'b1;
            cnt_d      = cnt_q - CNT_W'(1);
            addr_d     = (32'(addr_q) >= DEPTH - 1) ? '0 : addr_q + ADDR_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               burst_last_c = 1'b1;
               state_d      = DRAIN;
            end
         end
         DRAIN: begin
            if (pipe_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sram_rd_pipe #(
      .W      (W),
      .RD_LAT (LAT)
   ) u_rd_pipe (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (rd_en),
      .last_i       (burst_last_c),
      .empty_done_i (empty_done_c),
      .data_i       (rd_word),
      .rvalid_o     (rvalid),
      .done_o       (pipe_done),
      .rdata_o      (rdata)
   );

   assign burst_done = pipe_done;
   assign burst_busy = busy_q;

endmodule

// File: tb/tb_sram_weight_stream.sv
// Scoreboard bench: two instances (RD_LAT=2/BYPASS=1 and RD_LAT=1/BYPASS=0) share
// the same stimulus; expected words are queued with their due cycle.
module tb_sram_weight_stream;

   localparam int unsigned W = 128;

   logic           clk = 1'b0;
   logic           rst, csb, wsb, burst_start;
   logic [7:0]     wmask;
   logic [W-1:0]   wdata;
   logic [3:0]     waddr, raddr, burst_base;
   logic [4:0]     burst_len;
   logic [W-1:0]   rdata_w [2];
   logic [1:0]     rvalid_w, busy_w, done_w;

   typedef struct {
      int           due;
      bit           v;
      bit           done;
      bit           known;
      logic [W-1:0] d;
   } sb_t;

   sb_t            sbq [2][$];
   int unsigned    n_checks = 0;
   int unsigned    n_pass   = 0;
   int             rv_cnt [2];
   int             rv_base [2];
   int             cyc = 0;
   logic [W-1:0]   mem_m [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_weight_stream #(.RD_LAT(2), .BYPASS(1'b1)) dut_a (
      .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .wdata(wdata),
      .waddr(waddr), .raddr(raddr), .burst_start(burst_start), .burst_base(burst_base),
      .burst_len(burst_len), .rdata(rdata_w[0]), .rvalid(rvalid_w[0]),
      .burst_busy(busy_w[0]), .burst_done(done_w[0]));

   sram_weight_stream #(.RD_LAT(1), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .csb(csb), .wsb(wsb), .wmask(wmask), .wdata(wdata),
      .waddr(waddr), .raddr(raddr), .burst_start(burst_start), .burst_base(burst_base),
      .burst_len(burst_len), .rdata(rdata_w[1]), .rvalid(rvalid_w[1]),
      .burst_busy(busy_w[1]), .burst_done(done_w[1]));

   function automatic int lat(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                          input logic [7:0] m);
      logic [W-1:0] r;
      r = o;
      for (int l = 0; l < 8; l++) if (m[l]) r[l*16 +: 16] = n[l*16 +: 16];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Output monitor: pops the entry due this cycle and flags any stray strobe.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            sb_t          e;
            bit           ev, ed, ek;
            logic [W-1:0] exd;
            string        sfx;
            sfx = (i == 0) ? "a" : "b";
            ev = 1'b0; ed = 1'b0; ek = 1'b0; exd = '0;
            while (sbq[i].size() > 0 && sbq[i][0].due < cyc) begin
               chk({"late_", sfx}, 1'b0, 1'b1);
               void'(sbq[i].pop_front());
            end
            if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
               e = sbq[i].pop_front();
               ev = e.v; ed = e.done; ek = e.known; exd = e.d;
            end
            if (rvalid_w[i] || ev) chk({"rvalid_", sfx}, W'(rvalid_w[i]), W'(ev));
            if (rvalid_w[i] && ev && ek) chk({"rdata_", sfx}, rdata_w[i], exd);
            if (done_w[i] || ed) chk({"burst_done_", sfx}, W'(done_w[i]), W'(ed));
            if (rvalid_w[i]) rv_cnt[i]++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      csb = 1'b1; wsb = 1'b1; burst_start = 1'b0;
   endtask

   // One cycle with csb low: always a direct read at ra, plus a write when wr is set.
   task automatic drive(input bit wr, input logic [3:0] wa, input logic [W-1:0] wd,
                        input logic [7:0] wm, input logic [3:0] ra);
      sb_t          e;
      logic [W-1:0] merged;
      csb = 1'b0; wsb = !wr; waddr = wa; wdata = wd; wmask = wm; raddr = ra;
      merged = merge(mem_m[wa], wd, wm);
      for (int i = 0; i < 2; i++) begin
         e.due  = cyc + lat(i);
         e.v    = 1'b1;
         e.done = 1'b0;
         e.d    = (i == 0 && wr && wa == ra) ? merged : mem_m[ra];
         e.known = !$isunknown(e.d);
         sbq[i].push_back(e);
      end
      if (wr) mem_m[wa] = merged;
      step();
   endtask

   task automatic start_burst(input logic [3:0] base, input logic [4:0] len);
      sb_t e;
      csb = 1'b1; burst_start = 1'b1; burst_base = base; burst_len = len;
      for (int i = 0; i < 2; i++) begin
         if (len == 0) begin
            e.due = cyc + 1; e.v = 1'b0; e.done = 1'b1; e.known = 1'b0; e.d = '0;
            sbq[i].push_back(e);
         end else begin
            for (int j = 0; j < int'(len); j++) begin
               e.due   = cyc + 1 + j + lat(i);
               e.v     = 1'b1;
               e.done  = (j == int'(len) - 1);
               e.d     = mem_m[4'(int'(base) + j)];
               e.known = 1'b1;
               sbq[i].push_back(e);
            end
         end
      end
      step();
      burst_start = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sbq[0].size() + sbq[1].size()) > 0 && n < 64) begin
         step();
         n++;
      end
      chk("drain_timeout", W'(sbq[0].size() + sbq[1].size()), '0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rv_cnt = '{0, 0};
      rst = 1'b1; idle_in();
      wmask = '0; wdata = '0; waddr = '0; raddr = '0; burst_base = '0; burst_len = '0;
      repeat (3) step();
      for (int i = 0; i < 2; i++) begin
         chk("reset_rdata", rdata_w[i], '0);
         chk("reset_rvalid", W'(rvalid_w[i]), '0);
         chk("reset_busy", W'(busy_w[i]), '0);
         chk("reset_done", W'(done_w[i]), '0);
      end
      rst = 1'b0;
      step();

      // Fill every word, then read all of them back-to-back.
      for (int k = 0; k < 16; k++) drive(1'b1, 4'(k), {8{16'(k)}}, 8'hFF, 4'(k));
      for (int k = 0; k < 16; k++) drive(1'b0, 4'd0, '0, 8'h00, 4'(k));
      idle_in();
      wait_drain();

      // Lane masking.
      drive(1'b1, 4'd3, {W{1'b1}}, 8'hFF, 4'd0);
      drive(1'b1, 4'd3, '0, 8'b0000_0101, 4'd0);
      drive(1'b0, 4'd0, '0, 8'h00, 4'd3);
      idle_in();
      wait_drain();
      chk("mask_model", mem_m[3], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_0000_FFFF_0000);

      // Read-during-write: full and partial masks, then a plain re-read.
      drive(1'b1, 4'd5, {8{16'hA5A5}}, 8'hFF, 4'd5);
      drive(1'b1, 4'd5, {8{16'h3C3C}}, 8'h0F, 4'd5);
      drive(1'b0, 4'd0, '0, 8'h00, 4'd5);
      idle_in();
      wait_drain();

      // Wrapping burst with ignored direct reads while busy.
      start_burst(4'd14, 5'd4);
      for (int i = 0; i < 2; i++) chk("busy_high", W'(busy_w[i]), W'(1));
      csb = 1'b0; wsb = 1'b1; raddr = 4'd7;
      step();
      step();
      idle_in();
      wait_drain();
      for (int i = 0; i < 2; i++) chk("busy_low", W'(busy_w[i]), '0);

      // Empty burst, then a start pulse while busy.
      rv_base = rv_cnt;
      start_burst(4'd2, 5'd0);
      step();
      start_burst(4'd6, 5'd2);
      burst_start = 1'b1; burst_base = 4'd9; burst_len = 5'd3;
      step();
      burst_start = 1'b0;
      wait_drain();
      for (int i = 0; i < 2; i++) chk("ignored_start_cnt", W'(rv_cnt[i]), W'(rv_base[i] + 2));

      // Reset in the second busy cycle of a long burst.
      start_burst(4'd0, 5'd8);
      step();
      rst = 1'b1;
      step();
      sbq[0].delete();
      sbq[1].delete();
      for (int i = 0; i < 2; i++) begin
         chk("rst_mid_rvalid", W'(rvalid_w[i]), '0);
         chk("rst_mid_busy", W'(busy_w[i]), '0);
         chk("rst_mid_done", W'(done_w[i]), '0);
      end
      rst = 1'b0;
      step();
      start_burst(4'd0, 5'd2);
      wait_drain();
      for (int i = 0; i < 2; i++) chk("final_busy", W'(busy_w[i]), '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
